erasure_sequencer: RTL and testbench

- Controller that sequences the soft-decision erasure datapath over one Reed-Solomon codeword.
- For each symbol it issues 8 channel-sample reads, then 1 fading-gain read. It waits out the multiplier/divider pipeline, captures the three erasure flags, and hands the symbol result to the decoder through a valid/ready handshake.
- It replaces ad-hoc signal_count sequencing with an explicit FSM and supports back-pressure.

---
 rtl/erasure_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_erasure_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/erasure_sequencer.sv
// Erasure datapath sequencer: per symbol issues 8 sample reads and 1 fade read, waits out the pipeline, then hands the flags to the decoder.
// Optional per-flag erasure statistics are enabled by defining ERASURE_SEQ_STATS_EN.
module erasure_sequencer #(
    parameter int ADDR_WIDTH      = 11,
    parameter int FADE_ADDR_WIDTH = 8,
    parameter int BITS_PER_SYMBOL = 8,
    parameter int SYMBOLS_PER_CW  = 255,
    parameter int RD_LATENCY      = 2,
    parameter int PIPE_LATENCY    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       hold,
    output logic                       rden,
    output logic [ADDR_WIDTH-1:0]      rdaddress,
    output logic [FADE_ADDR_WIDTH-1:0] rdaddress_fade,
    output logic                       sample_valid,
    output logic [2:0]                 sample_index,
    output logic                       fade_valid,
    input  logic [2:0]                 erasure_flags,
    output logic                       sym_valid,
    input  logic                       sym_ready,
    output logic [2:0]                 sym_erasure,
    output logic [7:0]                 sym_index,
    output logic                       cw_done,
    output logic                       busy
`ifdef ERASURE_SEQ_STATS_EN
    ,
    output logic [7:0]                 erasure_count_0,
    output logic [7:0]                 erasure_count_1,
    output logic [7:0]                 erasure_count_2
`endif
);

    // Symbol counter is widened when a codeword has more than 256 symbols; sym_index shows the low byte.
    localparam int SYM_W     = ($clog2(SYMBOLS_PER_CW) > 8) ? $clog2(SYMBOLS_PER_CW) : 8;
    localparam int DRAIN_CYC = RD_LATENCY + PIPE_LATENCY;
    localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

    localparam logic [2:0]         BIT_LAST   = 3'(BITS_PER_SYMBOL - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYC - 1);
    localparam logic [SYM_W-1:0]   SYM_LAST   = SYM_W'(SYMBOLS_PER_CW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_FADE,
        S_DRAIN,
        S_EMIT,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t                     r_state;
    logic                       r_rden;
    logic [ADDR_WIDTH-1:0]      r_rdaddress;
    logic [FADE_ADDR_WIDTH-1:0] r_rdaddress_fade;
    logic [2:0]                 r_bit;
    logic [DRAIN_W-1:0]         r_drain;
    logic [SYM_W-1:0]           r_sym_idx;
    logic                       r_sym_valid;
    logic [2:0]                 r_sym_erasure;
    logic                       r_cw_done;

    logic                       r_sv_sr [RD_LATENCY];
    logic [2:0]                 r_si_sr [RD_LATENCY];
    logic                       r_fv_sr [RD_LATENCY];

    logic                       w_issue;
    logic                       w_fade;
    logic [SYM_W-1:0]           w_sym_next;

    function automatic logic [ADDR_WIDTH-1:0] base_addr(input logic [SYM_W-1:0] idx);
        return ADDR_WIDTH'(idx) * ADDR_WIDTH'(BITS_PER_SYMBOL);
    endfunction

    assign w_issue    = (r_state == S_ISSUE);
    assign w_fade     = (r_state == S_FADE);
    assign w_sym_next = r_sym_idx + SYM_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= S_IDLE;
            r_rden           <= 1'b0;
            r_rdaddress      <= '0;
            r_rdaddress_fade <= '0;
            r_bit            <= '0;
            r_drain          <= '0;
            r_sym_idx        <= '0;
            r_sym_valid      <= 1'b0;
            r_sym_erasure    <= '0;
            r_cw_done        <= 1'b0;
        end else begin
            r_cw_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sym_idx <= '0;
                        if (hold) begin
                            r_state <= S_PAUSE;
                        end else begin
                            r_state     <= S_ISSUE;
                            r_rden      <= 1'b1;
                            r_rdaddress <= '0;
                            r_bit       <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_bit == BIT_LAST) begin
                        r_state          <= S_FADE;
                        r_rdaddress_fade <= FADE_ADDR_WIDTH'(r_sym_idx);
                    end else begin
                        r_bit       <= r_bit + 3'd1;
                        r_rdaddress <= r_rdaddress + ADDR_WIDTH'(1);
                    end
                end
                S_FADE: begin
                    r_state <= S_DRAIN;
                    r_rden  <= 1'b0;
                    r_drain <= DRAIN_INIT;
                end
                S_DRAIN: begin
                    // Flags for this symbol are valid on the last drain cycle only.
                    if (r_drain == '0) begin
                        r_sym_erasure <= erasure_flags;
                        r_sym_valid   <= 1'b1;
                        r_state       <= S_EMIT;
                    end else begin
                        r_drain <= r_drain - DRAIN_W'(1);
                    end
                end
                S_EMIT: begin
                    if (sym_ready) begin
                        r_sym_valid <= 1'b0;
                        if (r_sym_idx == SYM_LAST) begin
                            r_state   <= S_DONE;
                            r_cw_done <= 1'b1;
                        end else begin
                            r_sym_idx <= w_sym_next;
                            if (hold) begin
                                r_state <= S_PAUSE;
                            end else begin
                                r_state     <= S_ISSUE;
                                r_rden      <= 1'b1;
                                r_rdaddress <= base_addr(w_sym_next);
                                r_bit       <= '0;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (!hold) begin
                        r_state     <= S_ISSUE;
                        r_rden      <= 1'b1;
                        r_rdaddress <= base_addr(r_sym_idx);
                        r_bit       <= '0;
                    end
                end
                S_DONE: begin
                    r_sym_idx <= '0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rden  <= 1'b0;
                end
            endcase
        end
    end

    // Read-latency alignment: sample/fade strobes follow their address by RD_LATENCY cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_sv_sr[i] <= 1'b0;
                r_si_sr[i] <= '0;
                r_fv_sr[i] <= 1'b0;
            end
        end else begin
            r_sv_sr[0] <= w_issue;
            r_si_sr[0] <= r_bit;
            r_fv_sr[0] <= w_fade;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_sv_sr[i] <= r_sv_sr[i-1];
                r_si_sr[i] <= r_si_sr[i-1];
                r_fv_sr[i] <= r_fv_sr[i-1];
            end
        end
    end

`ifdef ERASURE_SEQ_STATS_EN
    logic [7:0] r_ecnt [3];
    logic       w_start_acc;
    logic       w_accept;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_accept    = (r_state == S_EMIT) && sym_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < 3; n++) r_ecnt[n] <= '0;
        end else if (w_start_acc) begin
            for (int n = 0; n < 3; n++) r_ecnt[n] <= '0;
        end else if (w_accept) begin
            for (int n = 0; n < 3; n++) begin
                if (r_sym_erasure[n] && (r_ecnt[n] != 8'hFF)) r_ecnt[n] <= r_ecnt[n] + 8'd1;
            end
        end
    end

    assign erasure_count_0 = r_ecnt[0];
    assign erasure_count_1 = r_ecnt[1];
    assign erasure_count_2 = r_ecnt[2];
`endif

    assign rden           = r_rden;
    assign rdaddress      = r_rdaddress;
    assign rdaddress_fade = r_rdaddress_fade;
    assign sample_valid   = r_sv_sr[RD_LATENCY-1];
    assign sample_index   = r_si_sr[RD_LATENCY-1];
    assign fade_valid     = r_fv_sr[RD_LATENCY-1];
    assign sym_valid      = r_sym_valid;
    assign sym_erasure    = r_sym_erasure;
    assign sym_index      = r_sym_idx[7:0];
    assign cw_done        = r_cw_done;
    assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_erasure_sequencer.sv
// Directed bench for erasure_sequencer: read-order monitor plus a symbol scoreboard.
module tb_erasure_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        hold;
    logic        rden;
    logic [10:0] rdaddress;
    logic [7:0]  rdaddress_fade;
    logic        sample_valid;
    logic [2:0]  sample_index;
    logic        fade_valid;
    logic [2:0]  erasure_flags;
    logic        sym_valid;
    logic        sym_ready;
    logic [2:0]  sym_erasure;
    logic [7:0]  sym_index;
    logic        cw_done;
    logic        busy;
`ifdef ERASURE_SEQ_STATS_EN
    logic [7:0]  erasure_count_0;
    logic [7:0]  erasure_count_1;
    logic [7:0]  erasure_count_2;
`endif

    erasure_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .hold           (hold),
        .rden           (rden),
        .rdaddress      (rdaddress),
        .rdaddress_fade (rdaddress_fade),
        .sample_valid   (sample_valid),
        .sample_index   (sample_index),
        .fade_valid     (fade_valid),
        .erasure_flags  (erasure_flags),
        .sym_valid      (sym_valid),
        .sym_ready      (sym_ready),
        .sym_erasure    (sym_erasure),
        .sym_index      (sym_index),
        .cw_done        (cw_done),
        .busy           (busy)
`ifdef ERASURE_SEQ_STATS_EN
        ,
        .erasure_count_0(erasure_count_0),
        .erasure_count_1(erasure_count_1),
        .erasure_count_2(erasure_count_2)
`endif
    );

    typedef struct packed {
        logic [7:0] idx;
        logic [2:0] ers;
    } sym_t;

    sym_t       exp_q[$];
    int         checks;
    int         failures;
    logic       flag_mode;
    logic [2:0] const_flags;

    int         m_sym;
    int         m_phase;
    logic       sv_d1, sv_d2, fv_d1, fv_d2;
    logic [2:0] si_d1, si_d2;
    int         last_rd;
    int         last_fade;
    int         cw_pulses;

    // Datapath stand-in: flags depend on the symbol whose fade gain was read.
    function automatic logic [2:0] flag_fn(input logic [7:0] a);
        return {1'b0, a[0], (a % 8'd15) == 8'd0};
    endfunction

    assign erasure_flags = flag_mode ? flag_fn(rdaddress_fade) : const_flags;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_sym(input int i, input logic [2:0] e);
        sym_t s;
        s.idx = 8'(i);
        s.ers = e;
        exp_q.push_back(s);
    endtask

    // Monitor: read order, read-latency alignment and handshake scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            m_sym   = 0;
            m_phase = 0;
            sv_d1 = 1'b0; sv_d2 = 1'b0; fv_d1 = 1'b0; fv_d2 = 1'b0;
            si_d1 = '0;   si_d2 = '0;
        end else begin
            logic       cur_issue;
            logic       cur_fade;
            logic [2:0] cur_idx;
            sym_t       s;
            chk("sample_valid", 32'(sample_valid), 32'(sv_d2));
            if (sv_d2) chk("sample_index", 32'(sample_index), 32'(si_d2));
            chk("fade_valid", 32'(fade_valid), 32'(fv_d2));
            cur_issue = rden && (m_phase < 8);
            cur_fade  = rden && (m_phase == 8);
            cur_idx   = 3'(m_phase);
            if (cur_issue) begin
                chk("rdaddress", 32'(rdaddress), 32'(m_sym * 8 + m_phase));
                last_rd = int'(rdaddress);
                m_phase++;
            end else if (cur_fade) begin
                chk("rdaddress_fade", 32'(rdaddress_fade), 32'(m_sym));
                last_fade = int'(rdaddress_fade);
                m_phase = 0;
                m_sym++;
            end
            sv_d2 = sv_d1; si_d2 = si_d1; fv_d2 = fv_d1;
            sv_d1 = cur_issue; si_d1 = cur_idx; fv_d1 = cur_fade;
            if (sym_valid && sym_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'(1), 32'(0));
                end else begin
                    s = exp_q.pop_front();
                    chk("sb_sym_index", 32'(sym_index), 32'(s.idx));
                    chk("sb_sym_erasure", 32'(sym_erasure), 32'(s.ers));
                end
            end
            if (cw_done) begin
                cw_pulses++;
                m_sym = 0;
            end
        end
    end

    initial begin
        logic seen;
        checks = 0; failures = 0; cw_pulses = 0; last_rd = -1; last_fade = -1;
        reset = 1'b0; start = 1'b0; hold = 1'b0; sym_ready = 1'b1;
        flag_mode = 1'b0; const_flags = 3'b101;
        tick(3);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rden", 32'(rden), 32'(0));
        chk("rst_rdaddress", 32'(rdaddress), 32'(0));
        chk("rst_rdaddress_fade", 32'(rdaddress_fade), 32'(0));
        chk("rst_sym_valid", 32'(sym_valid), 32'(0));
        chk("rst_sym_index", 32'(sym_index), 32'(0));
        chk("rst_cw_done", 32'(cw_done), 32'(0));
        reset = 1'b1;
        tick(2);

        // First codeword: constant flags, interrupted by reset mid-DRAIN of symbol 3.
        for (int i = 0; i < 3; i++) push_sym(i, 3'b101);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("s0_rden", 32'(rden), 32'(1));
        chk("s0_addr", 32'(rdaddress), 32'(0));
        tick(14);
        chk("s0_valid_early", 32'(sym_valid), 32'(0));
        tick(1);
        chk("s0_valid", 32'(sym_valid), 32'(1));
        chk("s0_erasure", 32'(sym_erasure), 32'(3'b101));
        chk("s0_index", 32'(sym_index), 32'(0));
        tick(44);
        chk("s3_index", 32'(sym_index), 32'(3));
        chk("s3_drain_rden", 32'(rden), 32'(0));
        chk("s3_busy", 32'(busy), 32'(1));
        reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_rden", 32'(rden), 32'(0));
        chk("arst_sym_valid", 32'(sym_valid), 32'(0));
        chk("arst_sym_index", 32'(sym_index), 32'(0));
        tick(2);
        chk("sb_empty_a", 32'(exp_q.size()), 32'(0));
        reset = 1'b1;
        tick(1);

        // Second codeword: hold during symbol 4, back-pressure on symbol 10.
        for (int i = 0; i < 11; i++) push_sym(i, 3'b101);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("restart_addr", 32'(rdaddress), 32'(0));
        tick(65);
        hold = 1'b1;
        tick(15);
        chk("pause_rden", 32'(rden), 32'(0));
        chk("pause_busy", 32'(busy), 32'(1));
        chk("pause_sym_valid", 32'(sym_valid), 32'(0));
        chk("pause_sym_index", 32'(sym_index), 32'(5));
        tick(3);
        chk("pause_rden_late", 32'(rden), 32'(0));
        hold = 1'b0;
        tick(1);
        chk("resume_rden", 32'(rden), 32'(1));
        chk("resume_addr", 32'(rdaddress), 32'(40));
        tick(94);
        sym_ready = 1'b0;
        tick(1);
        chk("stall_valid", 32'(sym_valid), 32'(1));
        chk("stall_index", 32'(sym_index), 32'(10));
        const_flags = 3'b010;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("stall_hold_valid", 32'(sym_valid), 32'(1));
            chk("stall_hold_index", 32'(sym_index), 32'(10));
            chk("stall_hold_erasure", 32'(sym_erasure), 32'(3'b101));
            chk("stall_no_reads", 32'(rden), 32'(0));
        end
        const_flags = 3'b101;
        sym_ready = 1'b1;
        tick(1);
        chk("s11_rden", 32'(rden), 32'(1));
        chk("s11_addr", 32'(rdaddress), 32'(88));
        chk("sb_empty_b", 32'(exp_q.size()), 32'(0));
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);

        // Full codeword with per-symbol flags and an ignored start mid-run.
        flag_mode = 1'b1;
        for (int i = 0; i < 255; i++) push_sym(i, flag_fn(8'(i)));
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(100);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("busy_mid_cw", 32'(busy), 32'(1));
        seen = 1'b0;
        for (int n = 0; n < 4300 && !seen; n++) begin
            tick(1);
            if (cw_done) seen = 1'b1;
        end
        chk("cw_done_seen", 32'(seen), 32'(1));
`ifdef ERASURE_SEQ_STATS_EN
        chk("erasure_count_0", 32'(erasure_count_0), 32'(17));
        chk("erasure_count_1", 32'(erasure_count_1), 32'(127));
        chk("erasure_count_2", 32'(erasure_count_2), 32'(0));
`endif
        chk("last_rdaddress", 32'(last_rd), 32'(2039));
        chk("last_rdaddress_fade", 32'(last_fade), 32'(254));
        chk("sb_empty_c", 32'(exp_q.size()), 32'(0));
        start = 1'b1;
        tick(1);
        chk("done_to_idle_busy", 32'(busy), 32'(0));
        chk("cw_done_one_cycle", 32'(cw_done), 32'(0));
        chk("idle_sym_index", 32'(sym_index), 32'(0));
        chk("cw_pulses", 32'(cw_pulses), 32'(1));
        tick(1);
        start = 1'b0;
        chk("start_after_done_busy", 32'(busy), 32'(1));
        chk("start_after_done_addr", 32'(rdaddress), 32'(0));
        reset = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
